pc_sequencer: RTL and testbench

- Program-counter stage of the MiniRISC core; sits directly downstream of the 22-to-32-bit immediate sign-extender.
- Consumes the sign-extended 32-bit branch offset, a register jump target, and halt/stall controls from decode/execute.
- Produces the fetch address every cycle, a valid qualifier for the fetched instruction, and flush/halted status.
- Contains the redirect-bubble counter and the RUN/FLUSH/HALT state machine.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the MiniRISC program-counter stage.
package pc_sequencer_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter stage: produces the fetch address each cycle, inserts
// redirect bubbles after jumps/branches, and parks the core on halt.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned       PC_STEP      = 1,
    parameter int unsigned       FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_offset,
    input  logic              jump_reg,
    input  logic [DATA_W-1:0] jump_target,
    input  logic              halt,
    input  logic              resume,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_next_seq,
    output logic              instr_valid,
    output logic              flush,
    output logic              halted
);

    localparam logic [DATA_W-1:0] STEP       = DATA_W'(PC_STEP);
    localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_CYCLES);

    pc_state_t         state;
    pc_state_t         state_nx;
    logic [DATA_W-1:0] pc_nx;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nx;
    logic [DATA_W-1:0] pc_addend;
    logic [DATA_W-1:0] pc_sum;

    // Shared adder: branch offset when a branch is taken in RUN, else the step.
    always_comb begin
        pc_addend = STEP;
        if (state == ST_RUN && branch_taken) begin
            pc_addend = branch_offset;
        end
        pc_sum      = pc + pc_addend;
        pc_next_seq = pc + STEP;
    end

    // Next-state, next-pc and redirect flush pulse.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        flush    = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    state_nx = ST_HALT;
                end else if (jump_reg) begin
                    pc_nx    = jump_target;
                    flush    = 1'b1;
                    state_nx = ST_FLUSH;
                    cnt_nx   = FLUSH_INIT;
                end else if (branch_taken) begin
                    pc_nx    = pc_sum;
                    flush    = 1'b1;
                    state_nx = ST_FLUSH;
                    cnt_nx   = FLUSH_INIT;
                end else if (!stall) begin
                    pc_nx = pc_sum;
                end
            end
            ST_FLUSH: begin
                cnt_nx = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    state_nx = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    pc_nx    = pc_next_seq;
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_FLUSH;
                cnt_nx   = FLUSH_INIT;
            end
        endcase
    end

    // State, bubble counter and pc registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FLUSH;
            cnt   <= FLUSH_INIT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pc    <= pc_nx;
        end
    end

    // Status outputs are plain decodes of the registered state.
    always_comb begin
        instr_valid = (state == ST_RUN);
        halted      = (state == ST_HALT);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: one instance with a 1-cycle bubble and
// one with a 3-cycle bubble driven by the same stimulus.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump_reg;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;

    logic [31:0] pc1, pcns1, pc3, pcns3;
    logic        valid1, flush1, halted1;
    logic        valid3, flush3, halted3;

    typedef struct {
        bit          sel;
        logic [31:0] pc;
        logic        valid;
        logic        halted;
    } expect_t;

    expect_t sb[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    pc_sequencer dut1 (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump_reg(jump_reg), .jump_target(jump_target),
        .halt(halt), .resume(resume),
        .pc(pc1), .pc_next_seq(pcns1), .instr_valid(valid1),
        .flush(flush1), .halted(halted1)
    );

    pc_sequencer #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump_reg(jump_reg), .jump_target(jump_target),
        .halt(halt), .resume(resume),
        .pc(pc3), .pc_next_seq(pcns3), .instr_valid(valid3),
        .flush(flush3), .halted(halted3)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, optionally check the combinational flush
    // before the edge, then pop the expectation and check registered outputs.
    task automatic applyStimulus(
        input bit sel, input logic r, input logic st, input logic bt,
        input logic [31:0] bo, input logic jr, input logic [31:0] jt,
        input logic h, input logic rs, input bit chk_f, input logic ef,
        input logic [31:0] epc, input logic ev, input logic eh, input string tag);
        expect_t e;
        rst = r; stall = st; branch_taken = bt; branch_offset = bo;
        jump_reg = jr; jump_target = jt; halt = h; resume = rs;
        sb.push_back('{sel: sel, pc: epc, valid: ev, halted: eh});
        #1;
        if (chk_f) checkOutput({tag, ".flush"}, {31'd0, (sel ? flush3 : flush1)}, {31'd0, ef});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({tag, ".pc"},     e.sel ? pc3 : pc1, e.pc);
        checkOutput({tag, ".pcns"},   e.sel ? pcns3 : pcns1, e.pc + 32'd1);
        checkOutput({tag, ".valid"},  {31'd0, (e.sel ? valid3 : valid1)}, {31'd0, e.valid});
        checkOutput({tag, ".halted"}, {31'd0, (e.sel ? halted3 : halted1)}, {31'd0, e.halted});
        @(negedge clk);
    endtask

    task automatic idle(input bit sel, input logic [31:0] epc, input logic ev, input string tag);
        applyStimulus(sel, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0,
                      1'b1, 1'b0, epc, ev, 1'b0, tag);
    endtask

    // Directed scenario sequence.
    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'd0;
        jump_reg = 1'b0; jump_target = 32'd0; halt = 1'b0; resume = 1'b0;
        @(negedge clk);

        // Reset held two cycles, then one bubble, then sequential fetch.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, "rst_a");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, "rst_b");
        applyStimulus(0, 0, 0, 1, 32'd5, 0, 0, 0, 0, 1, 0, 32'd0, 1, 0, "rst_bubble");
        for (int i = 1; i <= 8; i++) idle(0, 32'(i), 1, "seq");

        // Backward branch from 8 to 4.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 1, 32'd4, 0, 0, "bbr");
        idle(0, 32'd4, 1, "bbr_t0");
        idle(0, 32'd5, 1, "bbr_t1");
        for (int i = 6; i <= 10; i++) idle(0, 32'(i), 1, "seq2");

        // Stall holds, then a jump overrides stall.
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'd10, 1, 0, "stall");
        applyStimulus(0, 0, 1, 0, 0, 1, 32'h100, 0, 0, 1, 1, 32'h100, 0, 0, "stall_jmp");
        idle(0, 32'h100, 1, "jmp_t0");

        // Halt at 20, ignore branches, resume to 21.
        applyStimulus(0, 0, 0, 0, 0, 1, 32'd20, 0, 0, 1, 1, 32'd20, 0, 0, "j20");
        idle(0, 32'd20, 1, "j20_t0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'd20, 0, 1, "halt");
        for (int k = 0; k < 5; k++)
            applyStimulus(0, 0, 0, (k % 2 == 0), 32'h40, 0, 0, 0, 0, 1, 0, 32'd20, 0, 1, "halt_hold");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd21, 1, 0, "resume");
        idle(0, 32'd22, 1, "after_resume");

        // Halt outranks a simultaneous branch: no flush.
        applyStimulus(0, 0, 0, 1, 32'd8, 0, 0, 1, 0, 1, 0, 32'd22, 0, 1, "halt_pri");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'd23, 1, 0, "resume2");

        // Reset while halted.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'd23, 0, 1, "halt2");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 0, 0, "rst_halt");
        applyStimulus(0, 0, 0, 1, 32'd9, 0, 0, 0, 0, 1, 0, 32'd0, 1, 0, "rst_halt_fl");
        idle(0, 32'd1, 1, "rst_halt_run");

        // Reset while flushing.
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 1, 1, 32'h40, 0, 0, "j40");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 0, 0, "rst_flush");
        idle(0, 32'd0, 1, "rst_flush_fl");
        idle(0, 32'd1, 1, "rst_flush_run");

        // Three-cycle bubble instance: reset latency, negative wrap, top wrap.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, "f3_rst");
        idle(1, 32'd0, 0, "f3_b1");
        idle(1, 32'd0, 0, "f3_b2");
        idle(1, 32'd0, 1, "f3_run");
        applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 0, "f3_negwrap");
        idle(1, 32'hFFFF_FFFF, 0, "f3_nb1");
        idle(1, 32'hFFFF_FFFF, 0, "f3_nb2");
        idle(1, 32'hFFFF_FFFF, 1, "f3_nrun");
        idle(1, 32'h0000_0000, 1, "f3_wrap0");
        applyStimulus(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 0, "f3_jtop");
        applyStimulus(1, 0, 0, 1, 32'd16, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, "f3_brbub");
        idle(1, 32'hFFFF_FFFF, 0, "f3_jb2");
        idle(1, 32'hFFFF_FFFF, 1, "f3_jrun");
        idle(1, 32'h0000_0000, 1, "f3_jwrap");
        idle(1, 32'h0000_0001, 1, "f3_jnext");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
